generic_fifo_env_param: RTL and testbench

GENERIC_FIFO_ENV_PARAM -- requirements
Module: generic_fifo_env_param

---
 rtl/generic_fifo_env_param.sv | 156 +++++++++++++++
 tb/tb_generic_fifo_env_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_env_param.sv
// Single-clock FIFO with per-bit masked writes, status flags and error pulses.
// Define GENERIC_FIFO_ENV_WATERMARK_EN to build the peak-occupancy (max_used) register.

module generic_fifo_env_ram #(
   parameter int DAT_WIDTH = 20,
   parameter int DEPTH     = 1024,
   parameter int AW        = 10
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DAT_WIDTH-1:0] wr_data,
   input  logic [DAT_WIDTH-1:0] wr_mask,
   input  logic [AW-1:0]        rd_addr,
   output logic [DAT_WIDTH-1:0] rd_row,
   input  logic                 scan_mode,
   input  logic                 sreset_n,
   input  logic [6:0]           ram_ctrl_vec
);

   logic [DAT_WIDTH-1:0] mem [DEPTH];

   // Test and macro controls only matter to a hard memory; the behavioural array ignores them.
   logic ctrl_unused;
   assign ctrl_unused = ^{scan_mode, sreset_n, ram_ctrl_vec};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   assign rd_row = mem[rd_addr];

endmodule

module generic_fifo_env_param #(
   parameter int DAT_WIDTH      = 20,
   parameter int PTR_WIDTH      = 10,
   parameter int NUM_OF_ENTRIES = 1024,
   parameter int AFULL_TH       = 1000,
   parameter int AEMPTY_TH      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 wr_op,
   input  logic [DAT_WIDTH-1:0] wr_data,
   input  logic [DAT_WIDTH-1:0] wr_mask,
   input  logic                 rd_op,
   output logic [DAT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic                 aempty,
   output logic [PTR_WIDTH:0]   entry_used,
   output logic                 wr_full_err,
   output logic                 rd_empty_err,
   output logic [PTR_WIDTH:0]   max_used,
   input  logic                 scan_mode,
   input  logic                 sreset_n,
   input  logic [6:0]           ram_ctrl_vec
);

   // Internal pointers are sized to the real depth so the array index carries no dead bits.
   localparam int AW = $clog2(NUM_OF_ENTRIES);
   localparam logic [AW-1:0]    LAST_PTR = AW'(NUM_OF_ENTRIES - 1);
   localparam logic [PTR_WIDTH:0] DEPTH_V  = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
   localparam logic [PTR_WIDTH:0] AFULL_V  = (PTR_WIDTH+1)'(AFULL_TH);
   localparam logic [PTR_WIDTH:0] AEMPTY_V = (PTR_WIDTH+1)'(AEMPTY_TH);
   localparam logic [PTR_WIDTH:0] ONE_V    = (PTR_WIDTH+1)'(1);

   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [DAT_WIDTH-1:0] rd_row;

   assign full   = (entry_used == DEPTH_V);
   assign empty  = (entry_used == '0);
   assign afull  = (entry_used >= AFULL_V);
   assign aempty = (entry_used <= AEMPTY_V);

   // A full FIFO still takes a write when a read frees the slot in the same cycle.
   always_comb begin
      rd_acc = rd_op & ~clr & ~empty;
      wr_acc = wr_op & ~clr & (~full | rd_acc);
   end

   generic_fifo_env_ram #(
      .DAT_WIDTH (DAT_WIDTH),
      .DEPTH     (NUM_OF_ENTRIES),
      .AW        (AW)
   ) u_ram (
      .clk          (clk),
      .wr_en        (wr_acc & reset_n),
      .wr_addr      (wr_ptr),
      .wr_data      (wr_data),
      .wr_mask      (wr_mask),
      .rd_addr      (rd_ptr),
      .rd_row       (rd_row),
      .scan_mode    (scan_mode),
      .sreset_n     (sreset_n),
      .ram_ctrl_vec (ram_ctrl_vec)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         entry_used <= '0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         entry_used <= '0;
      end else begin
         if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   entry_used <= entry_used + ONE_V;
            2'b01:   entry_used <= entry_used - ONE_V;
            default: entry_used <= entry_used;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         wr_full_err  <= 1'b0;
         rd_empty_err <= 1'b0;
      end else begin
         rd_valid     <= rd_acc;
         wr_full_err  <= wr_op & ~clr & full & ~rd_acc;
         rd_empty_err <= rd_op & ~clr & empty;
         if (rd_acc) rd_data <= rd_row;
      end
   end

`ifdef GENERIC_FIFO_ENV_WATERMARK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_used <= '0;
      end else if (clr) begin
         max_used <= '0;
      end else if (entry_used > max_used) begin
         max_used <= entry_used;
      end
   end
`else
   assign max_used = '0;
`endif

endmodule

// File: tb/tb_generic_fifo_env_param.sv
// Bench: scoreboarded random/directed traffic on a 5-deep instance plus threshold
// and flush checks on a default-parameter instance.

module tb_generic_fifo_env_param;

   localparam int SN = 5;
`ifdef GENERIC_FIFO_ENV_WATERMARK_EN
   localparam bit WM_ON = 1'b1;
`else
   localparam bit WM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       scan_mode, sreset_n;
   logic [6:0] ram_ctrl_vec;

   logic        s_clr, s_wr_op, s_rd_op, s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_wfe, s_ree;
   logic [19:0] s_wr_data, s_wr_mask, s_rd_data;
   logic [3:0]  s_used, s_max;

   logic        b_clr, b_wr_op, b_rd_op, b_rd_valid, b_full, b_empty, b_afull, b_aempty, b_wfe, b_ree;
   logic [19:0] b_wr_data, b_wr_mask, b_rd_data;
   logic [10:0] b_used, b_max;

   generic_fifo_env_param #(
      .DAT_WIDTH(20), .PTR_WIDTH(3), .NUM_OF_ENTRIES(SN), .AFULL_TH(4), .AEMPTY_TH(1)
   ) u_small (
      .clk(clk), .reset_n(reset_n), .clr(s_clr), .wr_op(s_wr_op), .wr_data(s_wr_data),
      .wr_mask(s_wr_mask), .rd_op(s_rd_op), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .full(s_full), .empty(s_empty), .afull(s_afull), .aempty(s_aempty), .entry_used(s_used),
      .wr_full_err(s_wfe), .rd_empty_err(s_ree), .max_used(s_max),
      .scan_mode(scan_mode), .sreset_n(sreset_n), .ram_ctrl_vec(ram_ctrl_vec)
   );

   generic_fifo_env_param u_big (
      .clk(clk), .reset_n(reset_n), .clr(b_clr), .wr_op(b_wr_op), .wr_data(b_wr_data),
      .wr_mask(b_wr_mask), .rd_op(b_rd_op), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .full(b_full), .empty(b_empty), .afull(b_afull), .aempty(b_aempty), .entry_used(b_used),
      .wr_full_err(b_wfe), .rd_empty_err(b_ree), .max_used(b_max),
      .scan_mode(scan_mode), .sreset_n(sreset_n), .ram_ctrl_vec(ram_ctrl_vec)
   );

   // Reference model: FIFO of slot contents with a known-bits mask per slot.
   typedef struct {
      logic [19:0] data;
      logic [19:0] known;
   } rd_exp_t;

   rd_exp_t     exp_q[$];
   int          m_cnt, m_w, m_r, exp_max;
   logic [19:0] m_mem   [SN];
   logic [19:0] m_known [SN];
   bit          exp_rv, exp_wfe, exp_ree, mon_en;
   logic [19:0] last_data, last_known;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0; m_w = 0; m_r = 0; exp_max = 0;
      exp_rv = 0; exp_wfe = 0; exp_ree = 0;
      for (int i = 0; i < SN; i++) m_known[i] = '0;
      exp_q.delete();
      last_data  = '0;
      last_known = '1;
   endfunction

   function automatic void model_step(bit wr, logic [19:0] d, logic [19:0] m, bit rd, bit cl);
      int prev;
      bit rd_ok, wr_ok;
      prev = m_cnt;
      if (cl) begin
         m_cnt = 0; m_w = 0; m_r = 0; exp_max = 0;
         exp_rv = 0; exp_wfe = 0; exp_ree = 0;
         return;
      end
      rd_ok = rd && (m_cnt > 0);
      wr_ok = wr && ((m_cnt < SN) || rd_ok);
      if (rd_ok) begin
         exp_q.push_back('{m_mem[m_r], m_known[m_r]});
         m_r = (m_r + 1) % SN;
      end
      if (wr_ok) begin
         m_mem[m_w]   = (m_mem[m_w] & ~m) | (d & m);
         m_known[m_w] = m_known[m_w] | m;
         m_w = (m_w + 1) % SN;
      end
      m_cnt   = m_cnt + int'(wr_ok) - int'(rd_ok);
      exp_rv  = rd_ok;
      exp_wfe = wr && !wr_ok;
      exp_ree = rd && !rd_ok;
      if (WM_ON && prev > exp_max) exp_max = prev;
   endfunction

   // Model steps on every active edge from the inputs the stimulus presented.
   always @(posedge clk) begin
      if (mon_en && reset_n === 1'b1) model_step(s_wr_op, s_wr_data, s_wr_mask, s_rd_op, s_clr);
   end

   always @(negedge clk) begin : monitor
      rd_exp_t e;
      if (mon_en) begin
         chk("rd_valid", s_rd_valid, exp_rv);
         if (s_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underflow: got rd_valid=1 expected no pending read at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               last_data  = e.data;
               last_known = e.known;
            end
         end
         chk("rd_data", s_rd_data & last_known, last_data & last_known);
         chk("entry_used", s_used, m_cnt);
         chk("full", s_full, m_cnt == SN);
         chk("empty", s_empty, m_cnt == 0);
         chk("afull", s_afull, m_cnt >= 4);
         chk("aempty", s_aempty, m_cnt <= 1);
         chk("wr_full_err", s_wfe, exp_wfe);
         chk("rd_empty_err", s_ree, exp_ree);
         chk("max_used", s_max, exp_max);
      end
   end

   task automatic s_cycle(input bit wr, input logic [19:0] d, input logic [19:0] m, input bit rd, input bit cl);
      @(negedge clk);
      s_wr_op = wr; s_wr_data = d; s_wr_mask = m; s_rd_op = rd; s_clr = cl;
      @(posedge clk);
   endtask

   task automatic s_idle(input int n);
      for (int i = 0; i < n; i++) s_cycle(0, '0, '0, 0, 0);
   endtask

   // Asynchronous reset with requests held active throughout; all must be ignored.
   task automatic apply_reset();
      reset_n = 1'b0;
      model_reset();
      mon_en = 1'b1;
      #1;
      chk("rst_rd_valid", s_rd_valid, 0);
      chk("rst_rd_data", s_rd_data, 0);
      chk("rst_entry_used", s_used, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_aempty", s_aempty, 1);
      chk("rst_full", s_full, 0);
      chk("rst_big_empty", b_empty, 1);
      chk("rst_big_afull", b_afull, 0);
      chk("rst_big_max", b_max, 0);
      s_wr_op = 1'b1; s_rd_op = 1'b1; s_wr_data = 20'h5A5A5; s_wr_mask = '1;
      repeat (2) @(negedge clk);
      s_wr_op = 1'b0; s_rd_op = 1'b0; s_clr = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic b_cycle(input bit wr, input logic [19:0] d, input bit rd, input bit cl);
      @(negedge clk);
      b_wr_op = wr; b_wr_data = d; b_rd_op = rd; b_clr = cl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [19:0] d, m;
      scan_mode = 0; sreset_n = 1; ram_ctrl_vec = '0;
      s_clr = 0; s_wr_op = 0; s_rd_op = 0; s_wr_data = '0; s_wr_mask = '0;
      b_clr = 0; b_wr_op = 0; b_rd_op = 0; b_wr_data = '0; b_wr_mask = '1;
      mon_en = 0;
      apply_reset();
      s_idle(2);

      // Five writes then five back-to-back reads
      for (int i = 1; i <= 5; i++) s_cycle(1, 20'(i), '1, 0, 0);
      for (int i = 0; i < 5; i++) s_cycle(0, '0, '0, 1, 0);
      s_idle(2);

      // Fill, overflow attempt, then simultaneous traffic across the wrap point
      for (int i = 0; i < 5; i++) s_cycle(1, 20'h10 + 20'(i), '1, 0, 0);
      s_cycle(1, 20'hDEAD0, '1, 0, 0);
      for (int i = 0; i < 12; i++) s_cycle(1, 20'h200 + 20'(i), '1, 1, 0);
      for (int i = 0; i < 5; i++) s_cycle(0, '0, '0, 1, 0);
      s_idle(2);

      // Read and write on an empty FIFO
      s_cycle(1, 20'hABCDE, '1, 1, 0);
      s_cycle(0, '0, '0, 1, 0);
      s_idle(2);

      // Masked write over rows preloaded with all ones
      for (int i = 0; i < 5; i++) s_cycle(1, 20'hFFFFF, '1, 0, 0);
      for (int i = 0; i < 5; i++) s_cycle(0, '0, '0, 1, 0);
      s_cycle(1, 20'h00000, 20'h0000F, 0, 0);
      s_cycle(0, '0, '0, 1, 0);
      s_idle(2);

      // Flush with a same-cycle write
      for (int i = 0; i < 3; i++) s_cycle(1, 20'h300 + 20'(i), '1, 0, 0);
      s_cycle(1, 20'h77777, '1, 1, 1);
      s_idle(2);

      // Random traffic; memory-control pins toggled freely
      for (int i = 0; i < 400; i++) begin
         d = 20'($urandom);
         m = ($urandom_range(0, 3) == 0) ? 20'($urandom) : '1;
         scan_mode = 1'($urandom); sreset_n = 1'($urandom); ram_ctrl_vec = 7'($urandom);
         s_cycle(1'($urandom_range(0, 2) != 0), d, m, 1'($urandom_range(0, 2) != 0),
                 $urandom_range(0, 40) == 0);
      end
      scan_mode = 0; sreset_n = 1; ram_ctrl_vec = '0;
      s_idle(2);

      // Reset right after an accepted read: the pending rd_valid must never appear
      s_cycle(1, 20'h4444, '1, 0, 0);
      s_cycle(0, '0, '0, 1, 0);
      apply_reset();
      s_idle(3);
      for (int i = 0; i < 5; i++) s_cycle(1, 20'hFFFFF, '1, 0, 0);
      for (int i = 0; i < 5; i++) s_cycle(0, '0, '0, 1, 0);
      s_cycle(1, 20'h00000, 20'h0000F, 0, 0);
      s_cycle(0, '0, '0, 1, 0);
      s_idle(3);
      chk("sb_drained", exp_q.size(), 0);

      // Default-parameter instance: thresholds over a fill to 1000
      for (int k = 1; k <= 1000; k++) begin
         b_cycle(1, 20'(k), 0, 0);
         chk("big_entry_used", b_used, k);
         chk("big_afull", b_afull, k >= 1000);
         chk("big_aempty", b_aempty, k <= 8);
      end
      chk("big_full", b_full, 0);
      b_cycle(0, '0, 1, 0);
      chk("big_rd_valid", b_rd_valid, 1);
      chk("big_rd_data", b_rd_data, 1);
      b_cycle(0, '0, 1, 0);
      chk("big_rd_data2", b_rd_data, 2);
      chk("big_afull_998", b_afull, 0);
      b_cycle(0, '0, 0, 0);
      chk("big_rd_valid_idle", b_rd_valid, 0);
      chk("big_rd_data_hold", b_rd_data, 2);
      chk("big_max_used", b_max, WM_ON ? 1000 : 0);
      b_cycle(1, 20'h12345, 0, 1);
      chk("big_clr_used", b_used, 0);
      chk("big_clr_empty", b_empty, 1);
      chk("big_clr_max", b_max, 0);
      b_cycle(0, '0, 0, 0);
      chk("big_clr_used_hold", b_used, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
